axi_lite_to_apb: RTL and testbench

AXI_LITE_TO_APB -- requirements
Module: axi_lite_to_apb

---
 rtl/axi_lite_to_apb.sv | 151 +++++++++++++++
 tb/tb_axi_lite_to_apb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_to_apb.sv
// AXI-Lite slave to APB master bridge: one APB transfer in flight, with
// round-robin arbitration between the write and read channels.
module axi_lite_to_apb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // AXI-Lite write address
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  // AXI-Lite write data
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  // AXI-Lite write response
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  // AXI-Lite read address
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  // AXI-Lite read data
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  // APB master
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB = DATA_WIDTH / 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] WRESP  = 3'd3;
  localparam logic [2:0] RRESP  = 3'd4;

  logic [2:0] state;
  logic       wr_next;   // tie-break: 1 = write wins when both channels request
  logic       wr_req;
  logic       rd_req;
  logic       grant_wr;
  logic       grant_rd;

  // A write needs address and data together; a lone AW or W is never accepted.
  assign wr_req = aw_valid_i && w_valid_i;
  assign rd_req = ar_valid_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      if (wr_req && (!rd_req || wr_next)) grant_wr = 1'b1;
      else if (rd_req)                    grant_rd = 1'b1;
    end
  end

  assign aw_ready_o = grant_wr;
  assign w_ready_o  = grant_wr;
  assign ar_ready_o = grant_rd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      wr_next   <= 1'b1;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pstrb_o   <= '0;
      b_valid_o <= 1'b0;
      b_resp_o  <= 2'b00;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_resp_o  <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (grant_wr) begin
            paddr_o  <= aw_addr_i;
            pwrite_o <= 1'b1;
            pwdata_o <= w_data_i;
            pstrb_o  <= w_strb_i;
            psel_o   <= 1'b1;
            wr_next  <= 1'b0;
            state    <= SETUP;
          end else if (grant_rd) begin
            paddr_o  <= ar_addr_i;
            pwrite_o <= 1'b0;
            pwdata_o <= '0;
            pstrb_o  <= {STRB{1'b0}};
            psel_o   <= 1'b1;
            wr_next  <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // APB slave inputs are only looked at here.
          if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            if (pwrite_o) begin
              b_valid_o <= 1'b1;
              b_resp_o  <= {pslverr_i, 1'b0};
              state     <= WRESP;
            end else begin
              r_valid_o <= 1'b1;
              r_data_o  <= prdata_i;
              r_resp_o  <= {pslverr_i, 1'b0};
              state     <= RRESP;
            end
          end
        end
        WRESP: begin
          if (b_ready_i) begin
            b_valid_o <= 1'b0;
            state     <= IDLE;
          end
        end
        RRESP: begin
          if (r_ready_i) begin
            r_valid_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_to_apb.sv
// Directed bench for axi_lite_to_apb: inputs change 1 time unit after the
// rising edge, outputs are compared 1 unit later.
module tb_axi_lite_to_apb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] aw_addr_i = '0;
  logic        aw_valid_i = 1'b0;
  logic        aw_ready_o;
  logic [31:0] w_data_i = '0;
  logic [3:0]  w_strb_i = '0;
  logic        w_valid_i = 1'b0;
  logic        w_ready_o;
  logic [1:0]  b_resp_o;
  logic        b_valid_o;
  logic        b_ready_i = 1'b0;
  logic [31:0] ar_addr_i = '0;
  logic        ar_valid_i = 1'b0;
  logic        ar_ready_o;
  logic [31:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_valid_o;
  logic        r_ready_i = 1'b0;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i = 1'b0;
  logic [31:0] prdata_i = '0;
  logic        pslverr_i = 1'b0;

  int checks = 0;
  int errors = 0;

  axi_lite_to_apb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i),
    .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
    b_ready_i = 1'b0; r_ready_i = 1'b0;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
  endtask

  // Leaves time at posedge+1 with reset released: the next edge may grant.
  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    // ---------------- reset values ----------------
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_pwrite", pwrite_o, 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_pwdata", pwdata_o, 0);
    check("rst_pstrb", pstrb_o, 0);
    check("rst_bvalid", b_valid_o, 0);
    check("rst_bresp", b_resp_o, 0);
    check("rst_rvalid", r_valid_o, 0);
    check("rst_rdata", r_data_o, 0);
    check("rst_rresp", r_resp_o, 0);
    do_reset();

    // ---------------- single write, zero wait ----------------
    aw_addr_i = 32'h0001_0004; w_data_i = 32'hDEAD_BEEF; w_strb_i = 4'hF;
    aw_valid_i = 1'b1; w_valid_i = 1'b1; pready_i = 1'b1; b_ready_i = 1'b1;
    #1;
    check("wr_c0_awready", aw_ready_o, 1);
    check("wr_c0_wready", w_ready_o, 1);
    check("wr_c0_arready", ar_ready_o, 0);
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    #1;
    check("wr_c1_psel", psel_o, 1);
    check("wr_c1_penable", penable_o, 0);
    check("wr_c1_paddr", paddr_o, 32'h0001_0004);
    check("wr_c1_awready", aw_ready_o, 0);
    tick(); #1;
    check("wr_c2_psel", psel_o, 1);
    check("wr_c2_penable", penable_o, 1);
    check("wr_c2_pwrite", pwrite_o, 1);
    check("wr_c2_pwdata", pwdata_o, 32'hDEAD_BEEF);
    check("wr_c2_pstrb", pstrb_o, 4'hF);
    tick(); #1;
    check("wr_c3_bvalid", b_valid_o, 1);
    check("wr_c3_bresp", b_resp_o, 2'b00);
    check("wr_c3_psel", psel_o, 0);
    tick(); #1;
    check("wr_c4_bvalid", b_valid_o, 0);

    // ---------------- read with wait states and slave error ----------------
    do_reset();
    ar_addr_i = 32'h10; ar_valid_i = 1'b1; r_ready_i = 1'b1;
    #1;
    check("rd_c0_arready", ar_ready_o, 1);
    check("rd_c0_awready", aw_ready_o, 0);
    tick();
    ar_valid_i = 1'b0;
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hBAD0_BAD0;  // must be ignored in SETUP
    #1;
    check("rd_setup_psel", psel_o, 1);
    check("rd_setup_penable", penable_o, 0);
    check("rd_setup_pwrite", pwrite_o, 0);
    tick();
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        pready_i = 1'b1; prdata_i = 32'h1234_5678; pslverr_i = 1'b1;
      end
      #1;
      check("rd_acc_penable", penable_o, 1);
      check("rd_acc_paddr", paddr_o, 32'h10);
      check("rd_acc_pstrb", pstrb_o, 0);
      check("rd_acc_pwdata", pwdata_o, 0);
      tick();
    end
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    #1;
    check("rd_rvalid", r_valid_o, 1);
    check("rd_rdata", r_data_o, 32'h1234_5678);
    check("rd_rresp", r_resp_o, 2'b10);
    check("rd_psel_drop", psel_o, 0);
    tick(); #1;
    check("rd_rvalid_done", r_valid_o, 0);

    // ---------------- round-robin with all channels valid ----------------
    do_reset();
    aw_addr_i = 32'h100; w_data_i = 32'hA5A5_A5A5; w_strb_i = 4'h3; ar_addr_i = 32'h200;
    aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
    pready_i = 1'b1; b_ready_i = 1'b1; r_ready_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      check("rr_awready", aw_ready_o, (c % 4 == 0) && ((c / 4) % 2 == 0));
      check("rr_arready", ar_ready_o, (c % 4 == 0) && ((c / 4) % 2 == 1));
      check("rr_psel", psel_o, (c % 4 == 1) || (c % 4 == 2));
      if (c % 4 == 1) check("rr_pwrite", pwrite_o, (c / 4) % 2 == 0);
      if (c % 4 == 3) begin
        check("rr_bvalid", b_valid_o, (c / 4) % 2 == 0);
        check("rr_rvalid", r_valid_o, (c / 4) % 2 == 1);
      end
      tick();
    end
    clear_inputs();

    // ---------------- AW without W, then held write response ----------------
    do_reset();
    aw_addr_i = 32'h44; w_data_i = 32'h0000_00FF; w_strb_i = 4'h1; aw_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("aw_only_awready", aw_ready_o, 0);
      check("aw_only_wready", w_ready_o, 0);
      check("aw_only_psel", psel_o, 0);
      tick();
    end
    w_valid_i = 1'b1;
    #1;
    check("aw_w_awready", aw_ready_o, 1);
    check("aw_w_wready", w_ready_o, 1);
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    ar_addr_i = 32'h20; ar_valid_i = 1'b1;
    pready_i = 1'b1; pslverr_i = 1'b1;
    tick();
    check("hold_access_pstrb", pstrb_o, 4'h1);
    tick();
    pready_i = 1'b0; pslverr_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("hold_bvalid", b_valid_o, 1);
      check("hold_bresp", b_resp_o, 2'b10);
      check("hold_arready", ar_ready_o, 0);
      tick();
    end
    b_ready_i = 1'b1;
    #1;
    check("hold_hs_arready", ar_ready_o, 0);
    tick();
    b_ready_i = 1'b0;
    #1;
    check("after_b_bvalid", b_valid_o, 0);
    check("after_b_arready", ar_ready_o, 1);
    tick();
    ar_valid_i = 1'b0;
    tick();
    pready_i = 1'b1; prdata_i = 32'hCAFE_0001; r_ready_i = 1'b1;
    tick();
    pready_i = 1'b0;
    #1;
    check("after_b_rvalid", r_valid_o, 1);
    check("after_b_rdata", r_data_o, 32'hCAFE_0001);
    check("after_b_rresp", r_resp_o, 2'b00);
    tick();

    // ---------------- reset mid-ACCESS ----------------
    do_reset();
    aw_addr_i = 32'h88; w_data_i = 32'h1111_2222; w_strb_i = 4'hC;
    aw_valid_i = 1'b1; w_valid_i = 1'b1; b_ready_i = 1'b1; r_ready_i = 1'b1;
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    tick();
    #1;
    check("mid_penable", penable_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("async_psel", psel_o, 0);
    check("async_penable", penable_o, 0);
    pready_i = 1'b1;
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("post_rst_bvalid", b_valid_o, 0);
      check("post_rst_rvalid", r_valid_o, 0);
      check("post_rst_psel", psel_o, 0);
      tick();
    end
    w_data_i = 32'h3333_4444; aw_valid_i = 1'b1; w_valid_i = 1'b1;
    #1;
    check("post_rst_awready", aw_ready_o, 1);
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    tick();
    check("post_rst_pwdata", pwdata_o, 32'h3333_4444);
    tick();
    check("post_rst_bvalid_new", b_valid_o, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
